// File: rtl/debug_cmd_pkg.sv
// debug_cmd_pkg: shared state, command and response types for debug_cmd_master.
package debug_cmd_pkg;

  localparam int unsigned DBG_ADDR_WIDTH = 15;
  localparam int unsigned DBG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DBG_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [DBG_DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DBG_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } rsp_t;

  // Bus completion: the bus returns rvalid for writes too, but writes report no data.
  function automatic rsp_t capture_rsp(input logic we, input logic [DBG_DATA_WIDTH-1:0] rdata);
    rsp_t r;
    r.rdata = we ? '0 : rdata;
    r.err   = 1'b0;
    return r;
  endfunction

  // Aborted transaction: no data, error flagged.
  function automatic rsp_t timeout_rsp();
    rsp_t r;
    r.rdata = '0;
    r.err   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/debug_cmd_timer.sv
// debug_cmd_timer: clear/enable/expire down-counter used to abort stuck bus transactions.
// Only built when DBG_CMD_TIMEOUT_EN is defined; without it the file is intentionally empty.
`ifdef DBG_CMD_TIMEOUT_EN
module debug_cmd_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] count_q;

  // Terminal count reached: CYCLES enabled cycles since the last clear.
  assign expired = (count_q == '0);

  // Load on clear, count down while enabled, hold at zero once expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= LOAD;
    end else if (clear) begin
      count_q <= LOAD;
    end else if (enable && !expired) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule
`endif

// File: rtl/debug_cmd_master.sv
// debug_cmd_master: single-outstanding bridge from a valid/ready command stream
// to req/gnt/rvalid debug bus transactions, with a valid/ready response channel.
// Optional feature: define DBG_CMD_TIMEOUT_EN to abort transactions after
// TIMEOUT_CYCLES cycles in REQ+WAIT and to swallow the late bus response.
//
// state | meaning
// IDLE  | ready for a command (held off while a late response is still owed)
// REQ   | dbg_req_o high with the registered command, waiting for grant
// WAIT  | granted, waiting for rvalid
// RSP   | response presented, waiting for rsp_ready_i
module debug_cmd_master
  import debug_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  dbg_req_o,
  output logic [ADDR_WIDTH-1:0] dbg_addr_o,
  output logic                  dbg_we_o,
  output logic [31:0]           dbg_wdata_o,
  input  logic                  dbg_gnt_i,
  input  logic                  dbg_rvalid_i,
  input  logic [31:0]           dbg_rdata_i
);

  if (ADDR_WIDTH != DBG_ADDR_WIDTH) begin : g_bad_addr_width
    $error("debug_cmd_master: ADDR_WIDTH must equal DBG_ADDR_WIDTH");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("debug_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   timeout;

`ifdef DBG_CMD_TIMEOUT_EN
  logic stale_q, stale_d;
  logic timer_clear, timer_enable;

  assign timer_clear  = (state_q == IDLE) && cmd_valid_i && cmd_ready_o;
  assign timer_enable = (state_q == REQ) || (state_q == WAIT);

  debug_cmd_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timeout)
  );

  // A late response from an aborted transaction must not pair with a new command.
  assign cmd_ready_o = (state_q == IDLE) && !stale_q;
`else
  assign timeout     = 1'b0;
  assign cmd_ready_o = (state_q == IDLE);
`endif

  assign dbg_req_o   = (state_q == REQ);
  assign dbg_addr_o  = cmd_q.addr;
  assign dbg_we_o    = cmd_q.we;
  assign dbg_wdata_o = cmd_q.wdata;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rsp_q.rdata;
  // err is only ever written by the timeout path, so it stays 0 without it.
  assign rsp_err_o   = rsp_q.err;

  // Next-state and next-register values; a bus exit event beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
`ifdef DBG_CMD_TIMEOUT_EN
    stale_d = stale_q;
    if (stale_q && dbg_rvalid_i) begin
      stale_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cmd_d   = '{addr: cmd_addr_i, we: cmd_we_i, wdata: cmd_wdata_i};
          state_d = REQ;
        end
      end
      REQ: begin
        if (dbg_gnt_i) begin
          state_d = WAIT;
        end else if (timeout) begin
          rsp_d   = timeout_rsp();
          state_d = RSP;
        end
      end
      WAIT: begin
        if (dbg_rvalid_i) begin
          rsp_d   = capture_rsp(cmd_q.we, dbg_rdata_i);
          state_d = RSP;
        end else if (timeout) begin
          rsp_d   = timeout_rsp();
`ifdef DBG_CMD_TIMEOUT_EN
          stale_d = 1'b1;
`endif
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef DBG_CMD_TIMEOUT_EN
  // Outstanding-late-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stale_q <= 1'b0;
    end else begin
      stale_q <= stale_d;
    end
  end
`endif

endmodule
